// File: rtl/sdio_zii_slave.sv
// Zorro II target for the SDIO card window. It holds a 4-entry register file and drives a mode-0 SPI shift engine.
// Optional build macro SDIO_IRQ_EN adds INT2_n, which signals completion of a transfer.
module sdio_zii_slave #(
   parameter logic [7:0] DIV_RESET = 8'd8,
   parameter logic [7:0] DIV_MIN   = 8'd0
) (
   input  logic        CLKCPU,
   input  logic        RESET_n,
   input  logic        AS_n,
   input  logic        UDS_n,
   input  logic        LDS_n,
   input  logic        RW_n,
   input  logic [23:1] A,
   input  logic [7:0]  BASE_SDIO,
   input  logic        SDIO_CONFIGURED_n,
   input  logic [15:0] D_IN,
   output logic [15:0] D_OUT,
   output logic        D_OE,
   output logic        DTACK_n,
   output logic        SD_CS_n,
   output logic        SD_SCK,
   output logic        SD_MOSI,
   input  logic        SD_MISO,
`ifdef SDIO_IRQ_EN
   output logic        INT2_n,
`endif
   input  logic        SD_CD_n
);

   localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_DIV = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT_END} bus_st_t;
   bus_st_t state;

   logic       hit, strobe, bus_rst_n, fire, wr_lo, rd;
   logic [1:0] reg_sel;
   logic [7:0] rdata, div_wr;
   logic [8:0] div_diff;
   logic       unused_bits;

   logic       cs_en, overrun, busy, sck, mosi, miso_s;
   logic [7:0] div, cnt, shift, rx;
   logic [2:0] bitcnt;
   logic       irq_bit, irq_en_bit;

   assign hit       = !SDIO_CONFIGURED_n && (A[23:16] == BASE_SDIO) && !AS_n;
   assign strobe    = !UDS_n || !LDS_n;
   assign reg_sel   = A[2:1];
   assign bus_rst_n = RESET_n && !AS_n;
   assign unused_bits = ^{A[15:3], D_IN[15:8]};

   // The FSM is held in IDLE while AS_n is high, so a register side effect can only
   // fire on the first strobed edge of each AS assertion.
   assign fire  = (state == ST_IDLE) && hit && strobe;
   assign wr_lo = fire && !RW_n && !LDS_n;
   assign rd    = fire && RW_n;

   assign div_diff = {1'b0, D_IN[7:0]} - {1'b0, DIV_MIN};
   assign div_wr   = div_diff[8] ? DIV_MIN : D_IN[7:0];

   always_ff @(posedge CLKCPU or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         state   <= ST_IDLE;
         DTACK_n <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: if (hit && strobe) begin
               state   <= ST_ACK;
               DTACK_n <= 1'b0;
            end
            ST_ACK:      state <= ST_WAIT_END;
            ST_WAIT_END: state <= ST_WAIT_END;
            default: begin
               state   <= ST_IDLE;
               DTACK_n <= 1'b1;
            end
         endcase
      end
   end

`ifdef SDIO_IRQ_EN
   logic irq_en, irq_pending;
   assign irq_bit    = irq_pending;
   assign irq_en_bit = irq_en;
   assign INT2_n     = !(irq_pending && irq_en);

   always_ff @(posedge CLKCPU or negedge RESET_n) begin
      if (!RESET_n) begin
         irq_en      <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         if (rd && (reg_sel == R_DATA || reg_sel == R_STATUS))
            irq_pending <= 1'b0;
         if (wr_lo && reg_sel == R_CTRL)
            irq_en <= D_IN[1];
         // Completion wins over a clearing read on the same edge.
         if (busy && cnt == 8'd0 && sck && bitcnt == 3'd7)
            irq_pending <= 1'b1;
      end
   end
`else
   assign irq_bit    = 1'b0;
   assign irq_en_bit = 1'b0;
`endif

   always_ff @(posedge CLKCPU or negedge RESET_n) begin
      if (!RESET_n) begin
         cs_en   <= 1'b0;
         div     <= DIV_RESET;
         overrun <= 1'b0;
         busy    <= 1'b0;
         sck     <= 1'b0;
         mosi    <= 1'b1;
         miso_s  <= 1'b0;
         cnt     <= 8'd0;
         shift   <= 8'd0;
         rx      <= 8'hFF;
         bitcnt  <= 3'd0;
      end else begin
         if (rd && reg_sel == R_STATUS)
            overrun <= 1'b0;

         if (wr_lo) begin
            case (reg_sel)
               R_CTRL: cs_en <= D_IN[0];
               R_DIV:  div   <= div_wr;
               R_DATA: if (busy) overrun <= 1'b1;
                       else begin
                          busy   <= 1'b1;
                          shift  <= D_IN[7:0];
                          mosi   <= D_IN[7];
                          cnt    <= div;
                          sck    <= 1'b0;
                          bitcnt <= 3'd0;
                       end
               default: ;
            endcase
         end

         // A new transfer can only start while idle, so this branch never collides with the start above.
         if (busy) begin
            if (cnt == 8'd0) begin
               cnt <= div;
               sck <= ~sck;
               if (!sck)
                  miso_s <= SD_MISO;
               else begin
                  shift <= {shift[6:0], miso_s};
                  if (bitcnt == 3'd7) begin
                     busy   <= 1'b0;
                     rx     <= {shift[6:0], miso_s};
                     mosi   <= 1'b1;
                     bitcnt <= 3'd0;
                  end else begin
                     mosi   <= shift[6];
                     bitcnt <= bitcnt + 3'd1;
                  end
               end
            end else
               cnt <= cnt - 8'd1;
         end
      end
   end

   always_comb begin
      rdata = 8'h00;
      case (reg_sel)
         R_DATA:   rdata = rx;
         R_STATUS: rdata = {3'b000, irq_bit, cs_en, overrun, !SD_CD_n, busy};
         R_CTRL:   rdata = {6'b000000, irq_en_bit, cs_en};
         R_DIV:    rdata = div;
         default:  rdata = 8'h00;
      endcase
   end

   assign D_OE    = hit && RW_n && RESET_n;
   assign D_OUT   = D_OE ? {8'h00, rdata} : 16'h0000;
   assign SD_CS_n = !cs_en;
   assign SD_SCK  = sck;
   assign SD_MOSI = mosi;

endmodule

// File: doc/sdio_zii_slave.md
Name: sdio_zii_slave

Overview:
- Zorro II / 68000 bus responder for the SDIO card's autoconfigured 64 KB window.
- Answers CPU cycles addressed to BASE_SDIO with DTACK and read data.
- Behind a small register file, drives an SPI-mode shift engine to the SD socket.
- The CPU (or a DMA master holding the bus) is the initiator; this block is the target.

Parameters:
- DIV_RESET, 8'd8, reset value of the SCK half-period divider (half-period = DIV+1 CLKCPU cycles).
- DIV_MIN, 8'd0, lowest divider value accepted; writes below it are clamped to it.

Ports:
- CLKCPU  in  1  7 MHz CPU clock; all state on rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- AS_n  in  1  bus address strobe; the master's current strobe.
- UDS_n  in  1  upper data strobe.
- LDS_n  in  1  lower data strobe.
- RW_n  in  1  1 = read, 0 = write.
- A  in  23  address A[23:1].
- BASE_SDIO  in  8  autoconfigured base, compared with A[23:16].
- SDIO_CONFIGURED_n  in  1  0 once the board is configured; the window is dead while 1.
- D_IN  in  16  bus data in.
- D_OUT  out  16  bus data out.
- D_OE  out  1  data output enable.
- DTACK_n  out  1  cycle acknowledge, active low.
- SD_CS_n  out  1  card chip select.
- SD_SCK  out  1  SPI clock, mode 0.
- SD_MOSI  out  1  SPI data out.
- SD_MISO  in  1  SPI data in.
- SD_CD_n  in  1  card detect, 0 = card present.

Behaviour:
- Reset (async, RESET_n=0):
  - DTACK_n=1, D_OE=0, D_OUT=0.
  - SD_CS_n=1, SD_SCK=0, SD_MOSI=1.
  - busy=0, rx=8'hFF, overrun=0, div=DIV_RESET, bit counter=0.
  - Bus FSM in IDLE. Reset mid-transfer aborts the transfer immediately with no SCK glitch beyond the reset edge.
- hit = !SDIO_CONFIGURED_n && A[23:16]==BASE_SDIO && !AS_n. Register select is A[2:1]; A[15:3] is ignored, so the registers mirror through the window.
- Registers sit in the low byte D[7:0]. Reads return 8'h00 on D[15:8].
  - 0 DATA: read returns the last received byte. A write with LDS_n=0 starts an 8-bit transfer of D_IN[7:0].
  - 1 STATUS, read-only: bit0 busy, bit1 card present (!SD_CD_n), bit2 overrun, bit3 SD_CS asserted. A read clears overrun.
  - 2 CONTROL: bit0=1 asserts SD_CS_n=0. Other bits read 0.
  - 3 DIVIDER: 8-bit half-period divider, clamped to >=DIV_MIN.
- Bus FSM states IDLE, ACK, WAIT_END.
  - IDLE -> ACK on the first rising edge with hit and (UDS_n=0 or LDS_n=0).
  - On that same edge: DTACK_n<=0, write data latched and register side effects applied (one-cycle latency to DTACK).
  - ACK -> WAIT_END on the next edge.
  - Any state -> IDLE with DTACK_n=1 asynchronously when AS_n=1. DTACK is never held past AS.
  - A write with only UDS_n=0 is acknowledged but has no effect.
  - Each register side effect fires exactly once per AS assertion.
- D_OE = hit && RW_n (combinational). D_OUT is valid from the decode, before DTACK.
- SPI engine, mode 0, MSB first:
  - On a DATA write while busy=0: busy<=1, shift<=data, MOSI=bit7, half-period counter loaded with div.
  - Each counter expiry toggles SCK. On a rising SCK, MISO is sampled into the shift LSB. On a falling SCK, the shift moves left and MOSI is updated.
  - After the 8th falling edge: busy<=0, rx<=shift, SCK stays 0, MOSI<=1.
  - Transfer time = 16*(div+1) CLKCPU cycles from the write edge.
  - A DATA write while busy=1 is dropped, overrun<=1, and the transfer in flight is untouched.
  - CONTROL and DIVIDER writes during busy: CS takes effect immediately; the divider is taken at the next reload.
- A simultaneous STATUS read and overrun set gives overrun=1; the set wins.

Optional Feature:
- Macro SDIO_IRQ_EN.
- When defined:
  - Adds output INT2_n (open-drain style, active low) and CONTROL bit1 = irq enable.
  - irq_pending is set on transfer completion and cleared by a DATA read or a STATUS read.
  - INT2_n = !(irq_pending && enable). STATUS bit4 = irq_pending. Reset leaves INT2_n=1.
- When undefined: no INT2_n port, CONTROL bit1 and STATUS bit4 read 0.

Test Plan:
- SDIO_CONFIGURED_n=1, read at BASE_SDIO window -> D_OE=0, DTACK_n stays 1.
- BASE=8'hE9, DIVIDER=0, CONTROL=1, write 8'hA5 to E9_0000 -> DTACK_n low 1 edge after strobes; SCK shows 8 pulses over 16 cycles; MOSI pattern 10100101; with MISO tied high, DATA reads 8'hFF and busy=0.
- Second DATA write 3 cycles into a transfer with div=4 -> overrun=1 in STATUS; the first transfer completes unaltered; the next STATUS read shows overrun=0.
- UDS-only write of 16'h3C00 to DATA -> DTACK asserted, no transfer (busy=0).
- RESET_n pulsed low mid-transfer -> SD_CS_n=1, SCK=0, busy=0, DIVIDER reads DIV_RESET.
- With SDIO_IRQ_EN defined and enable set: complete a transfer -> INT2_n=0; read DATA -> INT2_n=1.
